pkt_rr_arb: RTL and testbench
=============================

Name: pkt_rr_arb

Overview:
- Packet-granular round-robin arbiter sitting directly downstream of NUM_SRC packet-buffer stages.
- Each buffer stage holds only complete packets; this block drives each stage's read enable.
- Selects one source holding a complete packet and drains it beat-by-beat until its last-word beat, then re-arbitrates.
- Forwards beats through a single registered output slot with ready/valid backpressure toward the egress.

Parameters:
- NUM_SRC, 4, number of upstream buffer stages (2..8).
- DATA_WIDTH, 256, payload width per beat.
- SRC_ID_W, 2, width of the source-index field; must satisfy 2^SRC_ID_W >= NUM_SRC.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- src_pkt_avail  in  NUM_SRC  per-source flag: at least one complete packet is buffered.
- src_rd_en  out  NUM_SRC  per-source read enable; a source pops one beat when its bit is high and it has data.
- src_vld  in  NUM_SRC  per-source beat-popped indication; the source echoes it in the same cycle as src_rd_en.
- src_lw  in  NUM_SRC  per-source last-word flag for the current head beat.
- src_pld  in  NUM_SRC*DATA_WIDTH  per-source head-beat payload; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; combinational from the source.
- out_vld  out  1  egress beat valid.
- out_rdy  in  1  egress ready.
- out_lw  out  1  egress last-word flag.
- out_pld  out  DATA_WIDTH  egress payload.
- out_src  out  SRC_ID_W  index of the source of the egress beat.
- proto_err  out  1  sticky protocol-error flag, cleared only by rst.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, grant=0.
  - src_rd_en=0, out_vld=0, out_lw=0, out_pld=0, out_src=0, proto_err=0.
  - rst mid-packet abandons the packet; the sources are reset by the same signal.
- Output slot:
  - slot_free = !out_vld | out_rdy.
  - out_* registers load when a beat is accepted.
  - out_vld clears when out_rdy=1 and no new beat is accepted.
  - Holding out_rdy=0 keeps out_* stable.
- State IDLE:
  - src_rd_en=0.
  - If any src_pkt_avail bit is set, grant = first set bit searching from rr_ptr upward, with wrap modulo NUM_SRC; next state XFER.
  - Otherwise stay in IDLE.
- State XFER:
  - src_rd_en = one-hot(grant) & {NUM_SRC{slot_free}}.
  - A beat is accepted when src_rd_en[grant] & src_vld[grant]; out_pld/out_lw/out_src are captured at that same edge (latency: pop cycle t -> out_vld at t+1).
  - An accepted beat with src_lw[grant]=1 sets next state IDLE and rr_ptr=(grant+1) mod NUM_SRC.
  - An accepted beat with src_lw=0 keeps the state in XFER.
- Arbitration timing:
  - Exactly one IDLE bubble cycle between packets.
  - Minimum packet throughput is (beats+1) cycles when out_rdy=1.
  - In IDLE, src_pkt_avail already reflects the counter decrement caused by the previous last beat.
- Fairness: each source holding a packet is served within NUM_SRC-1 other packets.
- Protocol errors (set proto_err; the offending beat is ignored and not forwarded):
  - src_vld[i]=1 while src_rd_en[i]=0.
  - In XFER, src_rd_en[grant]=1 and src_vld[grant]=0 (granted source claimed a packet but delivered no beat); the state is unchanged.
- Packet integrity: a packet is never interleaved with another source's beats; out_src is constant from the first beat through the out_lw beat.
- Simultaneous events: the output slot may drain (out_rdy) and load a new beat in the same cycle; full throughput is one beat per cycle.

Test Plan:
- Single source, 3-beat packet:
  - Stimulus: NUM_SRC=4; src2 avail, pld 0xA1/0xA2/0xA3, lw on beat 3, out_rdy=1.
  - Required: one IDLE cycle; src_rd_en=4'b0100 for 3 cycles; out beats 0xA1..0xA3 with out_src=2 and out_lw only on 0xA3; rr_ptr=3 afterwards.
- Round-robin rotation:
  - Stimulus: all four sources continuously avail with 1-beat packets.
  - Required: out_src sequence 0,1,2,3,0,1 with a 1-cycle bubble between beats.
- Backpressure:
  - Stimulus: mid-packet, out_rdy=0 for 5 cycles.
  - Required: src_rd_en=0 once out_vld=1; out_pld held stable; no beat lost or duplicated after out_rdy returns to 1.
- No interleave:
  - Stimulus: src0 sends a 4-beat packet; src1 becomes avail at beat 2.
  - Required: all 4 src0 beats are forwarded before any src1 beat; src1 is granted after one IDLE cycle.
- Protocol error:
  - Stimulus: src3 asserts src_vld while src_rd_en[3]=0.
  - Required: proto_err=1 next cycle and stays 1; the src3 beat does not appear on out_*.
- Reset mid-packet:
  - Stimulus: assert rst during beat 2 of a 4-beat packet.
  - Required: out_vld=0, src_rd_en=0 and state IDLE immediately; after release, arbitration starts at source 0.

Source files
------------

// File: rtl/pkt_rr_arb.sv
// Packet-granular round-robin arbiter. Grants one upstream packet buffer at a
// time, drains it beat-by-beat up to its last word, and forwards beats through
// a single registered output slot with ready/valid backpressure.
module pkt_rr_arb #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned SRC_ID_W   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_pkt_avail,
  output logic [NUM_SRC-1:0]            src_rd_en,
  input  logic [NUM_SRC-1:0]            src_vld,
  input  logic [NUM_SRC-1:0]            src_lw,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_pld,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic                          out_lw,
  output logic [DATA_WIDTH-1:0]         out_pld,
  output logic [SRC_ID_W-1:0]           out_src,
  output logic                          proto_err
);

  typedef logic [SRC_ID_W-1:0] idx_t;
  typedef logic [SRC_ID_W:0]   wide_t;
  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  localparam idx_t  LastIdx = idx_t'(NUM_SRC - 1);
  localparam wide_t NumSrcW = wide_t'(NUM_SRC);

  state_e state_q, state_d;
  idx_t   rr_ptr_q, rr_ptr_d;
  idx_t   grant_q, grant_d;

  logic                  out_vld_q, out_lw_q, proto_err_q, proto_err_d;
  logic [DATA_WIDTH-1:0] out_pld_q;
  idx_t                  out_src_q;

  logic                  slot_free, accept;
  logic [NUM_SRC-1:0]    grant_oh;
  logic                  grant_rd, grant_vld, grant_lw;
  logic [DATA_WIDTH-1:0] grant_pld;

  logic [2*NUM_SRC-1:0]  avail_dbl;
  logic [NUM_SRC-1:0]    avail_rot;
  logic                  pick_found;
  idx_t                  pick_off, pick;
  wide_t                 pick_sum;

  assign slot_free = !out_vld_q || out_rdy;

  // Rotate the availability vector so bit 0 corresponds to rr_ptr.
  assign avail_dbl = {src_pkt_avail, src_pkt_avail};
  assign avail_rot = NUM_SRC'(avail_dbl >> rr_ptr_q);

  // First available source at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!pick_found && avail_rot[i]) begin
        pick_found = 1'b1;
        pick_off   = idx_t'(i);
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (pick_sum >= NumSrcW) begin
      pick_sum = pick_sum - NumSrcW;
    end
    pick = idx_t'(pick_sum);
  end

  // Decode the grant, drive read enables and select the granted source's beat.
  always_comb begin
    grant_pld = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      grant_oh[i]  = (grant_q == idx_t'(i));
      src_rd_en[i] = (state_q == StXfer) && slot_free && grant_oh[i];
      if (grant_oh[i]) begin
        grant_pld = src_pld[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    grant_rd  = |(src_rd_en & grant_oh);
    grant_vld = |(src_vld & grant_oh);
    grant_lw  = |(src_lw & grant_oh);
  end

  assign accept = (state_q == StXfer) && grant_rd && grant_vld;

  // Sticky error: a pop nobody asked for, or a granted read that produced no beat.
  assign proto_err_d = proto_err_q || (|(src_vld & ~src_rd_en)) ||
                       ((state_q == StXfer) && grant_rd && !grant_vld);

  // Next-state logic for arbitration and packet draining.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (accept && grant_lw) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_q == LastIdx) ? '0 : grant_q + idx_t'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Output slot: load on accept, otherwise drain when egress is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_lw_q  <= 1'b0;
      out_pld_q <= '0;
      out_src_q <= '0;
    end else if (accept) begin
      out_vld_q <= 1'b1;
      out_lw_q  <= grant_lw;
      out_pld_q <= grant_pld;
      out_src_q <= grant_q;
    end else if (out_rdy) begin
      out_vld_q <= 1'b0;
    end
  end

  assign out_vld   = out_vld_q;
  assign out_lw    = out_lw_q;
  assign out_pld   = out_pld_q;
  assign out_src   = out_src_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Directed bench for pkt_rr_arb: behavioural packet buffers on the source side,
// an egress beat log, and one task per scenario with hand-computed expectations.
module tb_pkt_rr_arb;
  localparam int NumSrc = 4;
  localparam int Dw     = 256;
  localparam int Iw     = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NumSrc-1:0]    src_pkt_avail, src_rd_en, src_vld, src_lw;
  logic [NumSrc*Dw-1:0] src_pld;
  logic                 out_vld, out_rdy, out_lw, proto_err;
  logic [Dw-1:0]        out_pld;
  logic [Iw-1:0]        out_src;
  logic [NumSrc-1:0]    inj_vld;

  int checks = 0;
  int errors = 0;

  pkt_rr_arb #(.NUM_SRC(NumSrc), .DATA_WIDTH(Dw), .SRC_ID_W(Iw)) dut (
    .clk(clk), .rst(rst),
    .src_pkt_avail(src_pkt_avail), .src_rd_en(src_rd_en), .src_vld(src_vld),
    .src_lw(src_lw), .src_pld(src_pld),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_lw(out_lw), .out_pld(out_pld),
    .out_src(out_src), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Source buffers: written by the stimulus tasks, popped on the clock.
  logic [7:0] mem_pld [NumSrc][64];
  logic       mem_lw  [NumSrc][64];
  int wr_ptr [NumSrc];
  int rd_ptr [NumSrc];
  int pushed [NumSrc];
  int popped [NumSrc];

  always_comb begin
    src_pkt_avail = '0;
    src_vld       = '0;
    src_lw        = '0;
    src_pld       = '0;
    for (int s = 0; s < NumSrc; s++) begin
      src_pkt_avail[s]     = (pushed[s] != popped[s]);
      src_vld[s]           = (src_rd_en[s] && (rd_ptr[s] != wr_ptr[s])) || inj_vld[s];
      src_lw[s]            = mem_lw[s][rd_ptr[s]];
      src_pld[s*Dw +: Dw]  = Dw'(mem_pld[s][rd_ptr[s]]);
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int s = 0; s < NumSrc; s++) begin
      if (rst) begin
        rd_ptr[s] <= wr_ptr[s];
        popped[s] <= pushed[s];
      end else if (src_rd_en[s] && src_vld[s] && (rd_ptr[s] != wr_ptr[s])) begin
        rd_ptr[s] <= rd_ptr[s] + 1;
        if (mem_lw[s][rd_ptr[s]]) popped[s] <= popped[s] + 1;
      end
    end
  end

  // Egress log of every beat taken by the sink.
  int cyc = 0;
  int log_n = 0;
  logic [7:0]    log_pld [256];
  logic          log_lw  [256];
  logic [Iw-1:0] log_src [256];
  int            log_cyc [256];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && out_vld && out_rdy) begin
      log_pld[log_n] <= out_pld[7:0];
      log_lw[log_n]  <= out_lw;
      log_src[log_n] <= out_src;
      log_cyc[log_n] <= cyc;
      log_n          <= log_n + 1;
    end
  end

  task automatic push_pkt(input int s, input logic [7:0] first, input int n);
    for (int b = 0; b < n; b++) begin
      mem_pld[s][wr_ptr[s] + b] = first + 8'(b);
      mem_lw[s][wr_ptr[s] + b]  = (b == n - 1);
    end
    wr_ptr[s] = wr_ptr[s] + n;
    pushed[s] = pushed[s] + 1;
  endtask

  task automatic wait_log(input int target, input string name);
    for (int i = 0; i < 200 && log_n < target; i++) @(negedge clk);
    checks++;
    if (log_n < target) begin
      errors++;
      $display("FAIL %s timeout: beats got %0d want %0d", name, log_n, target);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_out_vld got %b want 0", out_vld); end
    checks++; if (src_rd_en !== 4'b0) begin errors++; $display("FAIL rst_rd_en got %b want 0000", src_rd_en); end
    checks++; if (out_lw !== 1'b0) begin errors++; $display("FAIL rst_out_lw got %b want 0", out_lw); end
    checks++; if (out_pld !== '0) begin errors++; $display("FAIL rst_out_pld got %h want 0", out_pld); end
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL rst_out_src got %0d want 0", out_src); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err got %b want 0", proto_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] exp_pld [3] = '{8'hA1, 8'hA2, 8'hA3};
    push_pkt(2, 8'hA1, 3);
    #1;
    checks++; if (src_rd_en !== 4'b0000) begin errors++; $display("FAIL single_bubble rd_en got %b want 0000", src_rd_en); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (src_rd_en !== 4'b0100) begin errors++; $display("FAIL single_rd_en beat %0d got %b want 0100", k, src_rd_en); end
      if (k > 0) begin
        checks++; if (out_vld !== 1'b1 || out_pld !== Dw'(exp_pld[k-1]) || out_src !== 2'd2 || out_lw !== 1'b0)
          begin errors++; $display("FAIL single_out beat %0d got v%b %h s%0d lw%b want v1 %h s2 lw0", k-1, out_vld, out_pld[7:0], out_src, out_lw, exp_pld[k-1]); end
      end
    end
    @(negedge clk);
    checks++; if (src_rd_en !== 4'b0000) begin errors++; $display("FAIL single_rd_en_end got %b want 0000", src_rd_en); end
    checks++; if (out_vld !== 1'b1 || out_pld !== Dw'(8'hA3) || out_src !== 2'd2 || out_lw !== 1'b1)
      begin errors++; $display("FAIL single_last got v%b %h s%0d lw%b want v1 a3 s2 lw1", out_vld, out_pld[7:0], out_src, out_lw); end
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL single_drain out_vld got %b want 0", out_vld); end
  endtask

  task automatic test_rotation();
    int base;
    int exp_src [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    logic [7:0] exp_pld [8] = '{8'h13, 8'h10, 8'h11, 8'h12, 8'h23, 8'h20, 8'h21, 8'h22};
    base = log_n;
    for (int s = 0; s < NumSrc; s++) begin
      push_pkt(s, 8'h10 + 8'(s), 1);
      push_pkt(s, 8'h20 + 8'(s), 1);
    end
    wait_log(base + 8, "rot_wait");
    for (int i = 0; i < 8; i++) begin
      checks++; if (int'(log_src[base+i]) != exp_src[i] || log_pld[base+i] !== exp_pld[i] || log_lw[base+i] !== 1'b1)
        begin errors++; $display("FAIL rot_beat %0d got s%0d %h lw%b want s%0d %h lw1", i, log_src[base+i], log_pld[base+i], log_lw[base+i], exp_src[i], exp_pld[i]); end
      if (i > 0) begin
        checks++; if (log_cyc[base+i] - log_cyc[base+i-1] != 2)
          begin errors++; $display("FAIL rot_gap %0d got %0d want 2", i, log_cyc[base+i] - log_cyc[base+i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    repeat (3) @(negedge clk);
    base = log_n;
    push_pkt(3, 8'hB1, 4);
    repeat (2) @(negedge clk);
    checks++; if (out_vld !== 1'b1 || out_pld !== Dw'(8'hB1)) begin errors++; $display("FAIL bp_first got v%b %h want v1 b1", out_vld, out_pld[7:0]); end
    out_rdy = 1'b0;
    #1;
    checks++; if (src_rd_en !== 4'b0000) begin errors++; $display("FAIL bp_rd_en got %b want 0000", src_rd_en); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (out_vld !== 1'b1 || out_pld !== Dw'(8'hB1) || src_rd_en !== 4'b0000)
        begin errors++; $display("FAIL bp_hold %0d got v%b %h rd%b want v1 b1 rd0000", k, out_vld, out_pld[7:0], src_rd_en); end
    end
    out_rdy = 1'b1;
    wait_log(base + 4, "bp_wait");
    for (int i = 0; i < 4; i++) begin
      checks++; if (log_pld[base+i] !== 8'hB1 + 8'(i) || log_src[base+i] !== 2'd3 || log_lw[base+i] !== (i == 3))
        begin errors++; $display("FAIL bp_beat %0d got %h s%0d lw%b want %h s3", i, log_pld[base+i], log_src[base+i], log_lw[base+i], 8'hB1 + 8'(i)); end
    end
    repeat (4) @(negedge clk);
    checks++; if (log_n != base + 4) begin errors++; $display("FAIL bp_no_dup got %0d beats want 4", log_n - base); end
  endtask

  task automatic test_no_interleave();
    int base;
    logic [7:0] exp_pld [5] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1};
    int exp_src [5] = '{0, 0, 0, 0, 1};
    int exp_gap [5] = '{0, 1, 1, 1, 2};
    base = log_n;
    push_pkt(0, 8'hC1, 4);
    repeat (2) @(negedge clk);
    push_pkt(1, 8'hD1, 1);
    wait_log(base + 5, "noint_wait");
    for (int i = 0; i < 5; i++) begin
      checks++; if (log_pld[base+i] !== exp_pld[i] || int'(log_src[base+i]) != exp_src[i] || log_lw[base+i] !== (i >= 3))
        begin errors++; $display("FAIL noint_beat %0d got %h s%0d lw%b want %h s%0d", i, log_pld[base+i], log_src[base+i], log_lw[base+i], exp_pld[i], exp_src[i]); end
      if (i > 0) begin
        checks++; if (log_cyc[base+i] - log_cyc[base+i-1] != exp_gap[i])
          begin errors++; $display("FAIL noint_gap %0d got %0d want %0d", i, log_cyc[base+i] - log_cyc[base+i-1], exp_gap[i]); end
      end
    end
  endtask

  task automatic test_proto_err();
    int base;
    repeat (3) @(negedge clk);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_before got %b want 0", proto_err); end
    base = log_n;
    mem_pld[3][rd_ptr[3]] = 8'hEE;
    mem_lw[3][rd_ptr[3]]  = 1'b1;
    inj_vld = 4'b1000;
    @(negedge clk);
    inj_vld = 4'b0000;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_set got %b want 1", proto_err); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL perr_no_fwd got out_vld %b want 0", out_vld); end
    repeat (3) @(negedge clk);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky got %b want 1", proto_err); end
    checks++; if (log_n != base || out_vld !== 1'b0) begin errors++; $display("FAIL perr_log got %0d beats v%b want 0 v0", log_n - base, out_vld); end
  endtask

  task automatic test_reset_mid();
    int base;
    repeat (2) @(negedge clk);
    base = log_n;
    push_pkt(2, 8'hE1, 4);
    repeat (2) @(negedge clk);
    checks++; if (src_rd_en !== 4'b0100 || out_vld !== 1'b1) begin errors++; $display("FAIL rmid_pre got rd%b v%b want rd0100 v1", src_rd_en, out_vld); end
    rst = 1'b1;
    #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rmid_out_vld got %b want 0", out_vld); end
    checks++; if (src_rd_en !== 4'b0000) begin errors++; $display("FAIL rmid_rd_en got %b want 0000", src_rd_en); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rmid_perr got %b want 0", proto_err); end
    @(negedge clk);
    rst = 1'b0;
    push_pkt(3, 8'hF1, 1);
    push_pkt(0, 8'h91, 1);
    #1;
    checks++; if (src_rd_en !== 4'b0000) begin errors++; $display("FAIL rmid_idle got %b want 0000", src_rd_en); end
    wait_log(base + 2, "rmid_wait");
    checks++; if (log_src[base] !== 2'd0 || log_pld[base] !== 8'h91)
      begin errors++; $display("FAIL rmid_first got s%0d %h want s0 91", log_src[base], log_pld[base]); end
    checks++; if (log_src[base+1] !== 2'd3 || log_pld[base+1] !== 8'hF1)
      begin errors++; $display("FAIL rmid_second got s%0d %h want s3 f1", log_src[base+1], log_pld[base+1]); end
  endtask

  initial begin
    rst     = 1'b1;
    out_rdy = 1'b1;
    inj_vld = '0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_no_interleave();
    test_proto_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
